// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding and default frame/baud parameters.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DIV_WIDTH  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: down-counter reloaded from div_i, one-clk tick_o when it hits zero.
// Latency: tick every div_i+1 clks; new divisor applies at next reload; no backpressure.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt;

  assign tick_o = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rstn)       cnt <= '0;
    else if (tick_o) cnt <= div_i;
    else             cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer (optional parity via UART_RX_PARITY_EN); valid_out rises 1 clk after stop sample.
// Holds data_o while valid_out & !ready_out; a word completing in that state is dropped with an overrun pulse.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  frame_err_o,
  output logic                  overrun_err_o,
  input  logic                  parity_odd_i,
  output logic                  parity_err_o
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = S_PARITY;
`else
  localparam rx_state_t AFTER_DATA = S_STOP;
`endif

  logic                  tick;
  logic                  rx_meta, rx_s;
  rx_state_t             state_q, state_d;
  logic [SW-1:0]         samp_q, samp_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  word_done, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                  parity_err_d;
`endif

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk    (clk),
    .rstn   (rstn),
    .div_i  (baud_div_i),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= S_IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Every state decision is gated by the baud tick; samp counts ticks within a bit.
  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            samp_d  = '0;
          end
        end
        S_START: begin
          if (samp_q == HALF_LAST) begin
            samp_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        S_DATA: begin
          if (samp_q == FULL_LAST) begin
            samp_d  = '0;
            shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = AFTER_DATA;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (samp_q == FULL_LAST) begin
            samp_d       = '0;
            parity_err_d = rx_s ^ (^shift_q) ^ parity_odd_i;
            state_d      = S_STOP;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (samp_q == FULL_LAST) begin
            samp_d = '0;
            if (rx_s) begin
              word_done = 1'b1;
              state_d   = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_o        <= '0;
      valid_out     <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      frame_err_o   <= frame_err_d;
      overrun_err_o <= word_done & valid_out & ~ready_out;
      if (word_done && (!valid_out || ready_out)) begin
        data_o    <= shift_q;
        valid_out <= 1'b1;
      end else if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) parity_err_o <= 1'b0;
    else       parity_err_o <= parity_err_d;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd_i;
  assign parity_err_o      = 1'b0;
`endif

endmodule
